// File: rtl/video_stream_repacker_pkg.sv
// Shared definitions for the video stream repacker: default geometry,
// residue counter width and the line-assembly state type.
package video_stream_repacker_pkg;

  localparam int PX_WIDTH_DEF   = 12;
  localparam int PX_PER_CLK_DEF = 4;
  localparam int DATA_WIDTH     = PX_WIDTH_DEF * PX_PER_CLK_DEF;
  localparam int CNT_W          = $clog2(PX_PER_CLK_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } rp_state_e;

  // Wide enough for residue + a full beat (2*PX_PER_CLK-1)
  function automatic int cnt_width(input int px_per_clk);
    return $clog2(px_per_clk) + 1;
  endfunction

endpackage

// File: rtl/video_stream_repacker_lane_compactor.sv
// Combinational lane compactor: moves a contiguous run of valid lanes down
// to lane 0 (unused lanes zeroed) and reports how many lanes were valid.
module lane_compactor
  import video_stream_repacker_pkg::*;
#(
  parameter int PX_WIDTH   = PX_WIDTH_DEF,
  parameter int PX_PER_CLK = PX_PER_CLK_DEF,
  parameter int CW         = CNT_W
) (
  input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data,
  input  logic [PX_PER_CLK-1:0]          px_val,
  output logic [PX_PER_CLK*PX_WIDTH-1:0] cmp_data,
  output logic [CW-1:0]                  cmp_cnt
);

  int off;

  always_comb begin
    off = 0;
    for (int j = PX_PER_CLK - 1; j >= 0; j--) begin
      if (px_val[j]) off = j;
    end

    cmp_cnt = '0;
    for (int j = 0; j < PX_PER_CLK; j++) begin
      cmp_cnt = cmp_cnt + CW'(px_val[j]);
    end

    // The run is contiguous, so lane j lands at j-off
    cmp_data = '0;
    for (int i = 0; i < PX_PER_CLK; i++) begin
      for (int j = 0; j < PX_PER_CLK; j++) begin
        if (px_val[j] && (j - off == i)) begin
          cmp_data[i*PX_WIDTH +: PX_WIDTH] = px_data[j*PX_WIDTH +: PX_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/video_stream_repacker.sv
// Repacks a sparse per-lane-valid pixel stream into dense words; only the
// last word of a line may be partial. One registered output stage.
module video_stream_repacker
  import video_stream_repacker_pkg::*;
#(
  parameter int PX_WIDTH   = PX_WIDTH_DEF,
  parameter int PX_PER_CLK = PX_PER_CLK_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
  input  logic [PX_PER_CLK-1:0]          px_data_val_i,
  input  logic                           line_start_i,
  input  logic                           line_end_i,
  input  logic                           frame_start_i,
  input  logic                           frame_end_i,
  output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
  output logic [PX_PER_CLK-1:0]          px_data_val_o,
  output logic                           line_start_o,
  output logic                           line_end_o,
  output logic                           frame_start_o,
  output logic                           frame_end_o,
  output logic                           err_o
);

  localparam int DW    = PX_WIDTH * PX_PER_CLK;
  localparam int CW    = cnt_width(PX_PER_CLK);
  localparam int CMB_N = 2 * PX_PER_CLK;
  localparam int IW    = $clog2(CMB_N);

  rp_state_e             state_q, state_d;
  logic [CW-1:0]         res_cnt_q, res_cnt_d;
  logic [PX_WIDTH-1:0]   res_q [PX_PER_CLK-1];
  logic [PX_WIDTH-1:0]   res_d [PX_PER_CLK-1];
  logic                  pend_ls_q, pend_ls_d;
  logic                  pend_fs_q, pend_fs_d;
  logic                  pend_fe_q, pend_fe_d;
  logic                  err_q, err_d;

  logic [DW-1:0]         cmp_data;
  logic [CW-1:0]         cmp_cnt;
  logic [PX_WIDTH-1:0]   cmb [CMB_N];
  logic [CW-1:0]         eff_cnt;
  logic [CW-1:0]         total;
  logic [IW-1:0]         cmb_idx;
  logic                  beat;
  logic                  accept;
  logic                  ls_now;
  logic                  fs_now;

  logic [DW-1:0]         data_p0, data_p1;
  logic [PX_PER_CLK-1:0] vld_p0, vld_p1;
  logic                  ls_p0, ls_p1;
  logic                  le_p0, le_p1;
  logic                  fs_p0, fs_p1;
  logic                  fe_p0, fe_p1;

  lane_compactor #(
    .PX_WIDTH   (PX_WIDTH),
    .PX_PER_CLK (PX_PER_CLK),
    .CW         (CW)
  ) u_lane_compactor (
    .px_data  (px_data_i),
    .px_val   (px_data_val_i),
    .cmp_data (cmp_data),
    .cmp_cnt  (cmp_cnt)
  );

  // Stage p0: residue followed by the compacted beat, in pixel order
  always_comb begin
    beat    = |px_data_val_i;
    // A new line_start discards whatever residue the old line left behind
    eff_cnt = (state_q == ACTIVE && !line_start_i) ? res_cnt_q : '0;
    total   = eff_cnt + cmp_cnt;
    for (int j = 0; j < CMB_N; j++) cmb[j] = '0;
    for (int j = 0; j < PX_PER_CLK - 1; j++) begin
      if (CW'(j) < eff_cnt) cmb[j] = res_q[j];
    end
    cmb_idx = '0;
    for (int i = 0; i < PX_PER_CLK; i++) begin
      cmb_idx      = IW'(eff_cnt) + IW'(i);
      cmb[cmb_idx] = cmp_data[i*PX_WIDTH +: PX_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    res_cnt_d = res_cnt_q;
    res_d     = res_q;
    pend_ls_d = pend_ls_q;
    pend_fs_d = pend_fs_q;
    pend_fe_d = pend_fe_q;
    err_d     = err_q;
    accept    = 1'b0;
    data_p0   = '0;
    vld_p0    = '0;
    ls_p0     = 1'b0;
    le_p0     = 1'b0;
    fs_p0     = 1'b0;
    fe_p0     = 1'b0;
    ls_now    = line_start_i | pend_ls_q;
    fs_now    = line_start_i ? frame_start_i : pend_fs_q;

    case (state_q)
      IDLE: begin
        if (beat) begin
          if (line_start_i) accept = 1'b1;
          else              err_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (beat) begin
          accept = 1'b1;
          if (line_start_i) err_d = 1'b1;
        end
      end
      FLUSH: begin
        for (int j = 0; j < PX_PER_CLK - 1; j++) begin
          if (CW'(j) < res_cnt_q) begin
            data_p0[j*PX_WIDTH +: PX_WIDTH] = res_q[j];
            vld_p0[j]                       = 1'b1;
          end
        end
        le_p0     = 1'b1;
        fe_p0     = pend_fe_q;
        pend_fe_d = 1'b0;
        pend_ls_d = 1'b0;
        pend_fs_d = 1'b0;
        res_cnt_d = '0;
        state_d   = IDLE;
        if (beat) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (line_end_i && total <= CW'(PX_PER_CLK)) begin
        for (int j = 0; j < PX_PER_CLK; j++) begin
          if (CW'(j) < total) begin
            data_p0[j*PX_WIDTH +: PX_WIDTH] = cmb[j];
            vld_p0[j]                       = 1'b1;
          end
        end
        ls_p0     = ls_now;
        fs_p0     = fs_now;
        le_p0     = 1'b1;
        fe_p0     = frame_end_i;
        pend_ls_d = 1'b0;
        pend_fs_d = 1'b0;
        res_cnt_d = '0;
        state_d   = IDLE;
      end else if (total >= CW'(PX_PER_CLK)) begin
        for (int j = 0; j < PX_PER_CLK; j++) begin
          data_p0[j*PX_WIDTH +: PX_WIDTH] = cmb[j];
        end
        vld_p0    = '1;
        ls_p0     = ls_now;
        fs_p0     = fs_now;
        pend_ls_d = 1'b0;
        pend_fs_d = 1'b0;
        for (int j = 0; j < PX_PER_CLK - 1; j++) res_d[j] = cmb[j + PX_PER_CLK];
        res_cnt_d = total - CW'(PX_PER_CLK);
        if (line_end_i) begin
          pend_fe_d = frame_end_i;
          state_d   = FLUSH;
        end else begin
          state_d   = ACTIVE;
        end
      end else begin
        for (int j = 0; j < PX_PER_CLK - 1; j++) res_d[j] = cmb[j];
        res_cnt_d = total;
        pend_ls_d = ls_now;
        pend_fs_d = fs_now;
        state_d   = ACTIVE;
      end
    end
  end

  // Stage p1: registered state and output word
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      res_cnt_q <= '0;
      pend_ls_q <= 1'b0;
      pend_fs_q <= 1'b0;
      pend_fe_q <= 1'b0;
      err_q     <= 1'b0;
      data_p1   <= '0;
      vld_p1    <= '0;
      ls_p1     <= 1'b0;
      le_p1     <= 1'b0;
      fs_p1     <= 1'b0;
      fe_p1     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_cnt_q <= res_cnt_d;
      pend_ls_q <= pend_ls_d;
      pend_fs_q <= pend_fs_d;
      pend_fe_q <= pend_fe_d;
      err_q     <= err_d;
      data_p1   <= data_p0;
      vld_p1    <= vld_p0;
      ls_p1     <= ls_p0;
      le_p1     <= le_p0;
      fs_p1     <= fs_p0;
      fe_p1     <= fe_p0;
    end
  end

  // Residue pixels are qualified by res_cnt_q, so they need no reset
  always_ff @(posedge clk_i) begin
    res_q <= res_d;
  end

  assign px_data_o     = data_p1;
  assign px_data_val_o = vld_p1;
  assign line_start_o  = ls_p1;
  assign line_end_o    = le_p1;
  assign frame_start_o = fs_p1;
  assign frame_end_o   = fe_p1;
  assign err_o         = err_q;

endmodule

// File: doc/video_stream_repacker.md
Name: video_stream_repacker

Overview:
- Reassembles a sparse pixel stream into dense words: valid lanes may start at any lane offset and not fill a whole word. Output words have all PX_PER_CLK lanes valid except the final word of a line.
- Sits downstream of the window-generation and per-window processing pipeline, whose per-lane valids arrive shifted or partial at line edges.
- Restores the packed stream format consumed by the line buffers and the video output path.

Parameters:
- PX_WIDTH, 12, bits per pixel.
- PX_PER_CLK, 4, pixels per clock word (≥2).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- px_data_i  in  PX_PER_CLK*PX_WIDTH  input lanes, packed [PX_PER_CLK][PX_WIDTH]; lane 0 holds the earliest pixel.
- px_data_val_i  in  PX_PER_CLK  per-lane valid; set bits form one contiguous run, at any start lane.
- line_start_i  in  1  first beat of a line; qualified by |px_data_val_i.
- line_end_i  in  1  last beat of a line; qualified.
- frame_start_i  in  1  coincides with line_start_i of the first line; qualified.
- frame_end_i  in  1  coincides with line_end_i of the last line; qualified.
- px_data_o  out  PX_PER_CLK*PX_WIDTH  packed output word.
- px_data_val_o  out  PX_PER_CLK  per-lane valid: all ones, or lanes 0..k-1 on the last word of a line.
- line_start_o  out  1  first output word of a line.
- line_end_o  out  1  last output word of a line.
- frame_start_o  out  1  with line_start_o of the first line.
- frame_end_o  out  1  with line_end_o of the last line.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, residue count 0, state IDLE, pending flags cleared, err_o cleared. Reset mid-line discards the residue and emits no partial word.
- Residue register holds up to PX_PER_CLK-1 pixels in lanes 0..cnt-1. Count width is $clog2(PX_PER_CLK)+1.
- Each valid beat:
  - Incoming valid pixels are compacted, in lane order, and appended after the residue.
  - total = cnt + popcount(px_data_val_i).
  - If total ≥ PX_PER_CLK: the first PX_PER_CLK pixels form an output word, and the remaining total-PX_PER_CLK pixels become the new residue.
- Output is registered; latency is 1 cycle from the input beat that completes a word.
- States: IDLE, ACTIVE, FLUSH.
  - IDLE → ACTIVE on a valid beat with line_start_i. A valid beat in IDLE without line_start_i: err_o set, beat dropped.
  - ACTIVE: accumulate and emit.
  - line_end_i beat with remainder 0: the last full word is emitted with line_end_o; → IDLE.
  - line_end_i beat whose total ≤ PX_PER_CLK: a single word (possibly partial) is emitted with line_end_o; → IDLE.
  - line_end_i beat whose total > PX_PER_CLK: the full word is emitted in cycle N+1 and the remainder in cycle N+2 with line_end_o. State is FLUSH during N+1; → IDLE after N+2.
- Partial word: lanes k..PX_PER_CLK-1 of px_data_o are 0, and px_data_val_o = (1<<k)-1.
- line_start_o / frame_start_o are latched on the line_start_i beat and emitted with the first output word of the line. frame_end_o is emitted with line_end_o.
- A beat carrying both line_start_i and line_end_i (line ≤ PX_PER_CLK pixels) yields one word with line_start_o and line_end_o both set.
- Precondition: at least one idle input cycle follows line_end_i.
  - A valid beat arriving while in FLUSH sets err_o; its pixels are discarded and the flush word still goes out.
  - line_start_i in ACTIVE sets err_o; the residue is discarded and a new line starts from that beat.
- err_o stays 1 until reset.
- Cycles with no output word: px_data_val_o = 0 and all flag outputs are 0.

Decomposition:
- Shared video package: localparam helpers DATA_WIDTH = PX_WIDTH*PX_PER_CLK and CNT_W; the state enum type (IDLE/ACTIVE/FLUSH).
- One natural sub-module: lane_compactor. It is combinational: it shifts the contiguous valid run down to lane 0 and outputs the popcount. It is reused by the window path.

Test Plan:
- Aligned 8-pixel line, PX_PER_CLK=4, two beats with val=1111 and line_start/line_end → two words at T+1 and T+2, val=1111, line_start_o on the first, line_end_o on the second.
- 8-pixel line offset by one lane: beats val=1110, 1111, 0001 → words P0..P3 and P4..P7, both full. line_end_o on the second word, in the cycle after the 0001 beat.
- 6-pixel line: val=1110 then 0111 with line_end → word P0..P3 full, then next cycle P4,P5 with val=0011, line_end_o.
- Line_end overflow: residue 3 then a line_end beat val=1111 → full word at N+1, 3-pixel word (val=0111, line_end_o) at N+2. A valid beat injected at N+1 → err_o=1 and that beat's pixels absent from the output.
- Frame: 2 lines of 4 pixels, frame_start with the first line, frame_end with the last → frame_start_o aligned with the first line_start_o, frame_end_o with the final line_end_o.
- Reset asserted mid-line with residue 2 → all outputs 0 immediately. After release, the new line starts cleanly with no stale pixels, and err_o=0.
